// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator: FSM state encoding and default widths.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } fib_state_t;

    localparam int FIB_WIDTH = 16;
    localparam int FIB_NW    = 16;

endpackage

// File: rtl/fib_adder.sv
// WIDTH-bit adder with carry-out, shared by the single-result and streaming paths.
module fib_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fibonacci_gen.sv
// Fibonacci generator: returns F(n) in one shot, or streams F(0)..F(n) over a
// valid/ready handshake; aborts with overflow once a term no longer fits WIDTH bits.
module fibonacci_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int NW    = FIB_NW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NW-1:0]    n,
    input  logic             stream,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             done,
    output logic             busy,
    output logic             overflow
);

    fib_state_t       state, state_nxt, launch_state;
    logic [WIDTH-1:0] a, b, sum, dout_q;
    logic [NW-1:0]    k, n_q;
    logic             b_ovf, carry, xfer, last;

    fib_adder #(.WIDTH(WIDTH)) u_adder (
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    // dout_valid is high for the whole of STREAM, so ready alone completes a handshake
    assign xfer = (state == STREAM) && dout_ready;
    assign last = (k == n_q);

    always_comb begin
        if (stream)
            launch_state = STREAM;
        else if (n <= NW'(1))
            launch_state = DONE;
        else
            launch_state = CALC;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? launch_state : IDLE;
            CALC:       if (last || carry) state_nxt = DONE;
            STREAM:     if (xfer && (last || b_ovf)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dout       = (state == STREAM) ? a : dout_q;
        dout_valid = (state == STREAM);
        done       = (state == DONE);
        busy       = (state == CALC) || (state == STREAM);
    end

    // b always runs one term ahead of a; b_ovf marks that b's true value lost its carry
    always_ff @(posedge clk) begin
        if (!reset) begin
            a        <= '0;
            b        <= '0;
            k        <= '0;
            n_q      <= '0;
            b_ovf    <= 1'b0;
            dout_q   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_q      <= n;
                        a        <= '0;
                        b        <= WIDTH'(1);
                        b_ovf    <= 1'b0;
                        overflow <= 1'b0;
                        k        <= stream ? '0 : NW'(1);
                        if (!stream && (n <= NW'(1)))
                            dout_q <= {{(WIDTH-1){1'b0}}, n[0]};
                    end
                end
                CALC: begin
                    if (last) begin
                        dout_q <= b;
                    end else if (carry) begin
                        dout_q   <= '1;
                        overflow <= 1'b1;
                    end else begin
                        a <= b;
                        b <= sum;
                        k <= k + NW'(1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last) begin
                            dout_q <= a;
                        end else if (b_ovf) begin
                            dout_q   <= a;
                            overflow <= 1'b1;
                        end else begin
                            a     <= b;
                            b     <= sum;
                            b_ovf <= carry;
                            k     <= k + NW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fibonacci_gen.md
FIBONACCI_GEN -- requirements
Module: fibonacci_gen

Interface
REQ-001 Parameter WIDTH, default 16: result width in bits, minimum 2.
REQ-002 Parameter NW, default 16: index width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-low.
REQ-005 Port start, input, 1: request pulse, sampled only in IDLE or DONE.
REQ-006 Port n, input, NW: index of the requested term, F(0)=0, F(1)=1; captured with start.
REQ-007 Port stream, input, 1: mode, captured with start; 0 = single result, 1 = emit F(0)..F(n).
REQ-008 Port dout, output, WIDTH: result or current stream term.
REQ-009 Port dout_valid, output, 1: stream term valid; always 0 in single mode.
REQ-010 Port dout_ready, input, 1: consumer accepts a stream term.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port busy, output, 1: high in CALC and STREAM.
REQ-013 Port overflow, output, 1: last job aborted because a term exceeded WIDTH bits.

Function
REQ-014 States: IDLE, CALC, STREAM, DONE; operands a, b (WIDTH); index k (NW); b_ovf flag.
REQ-015 Start in IDLE or DONE: captures n and stream; sets a=0, b=1, b_ovf=0; clears overflow; next state per REQ-016 to REQ-018. The captured n is unaffected by later changes to the n input.
REQ-016 Single mode, n<=1: next state DONE with dout=n.
REQ-017 Single mode, n>=2: next state CALC with k=1.
REQ-018 Stream mode: next state STREAM with k=0.
REQ-019 CALC, each cycle:
- k==n: dout<=b, go to DONE.
- Otherwise: a<=b, b<=a+b, k<=k+1.
REQ-020 CALC carry-out of a+b: no advance; dout<=all-ones, overflow<=1, go to DONE.
REQ-021 Single-mode latency: done asserts n+1 cycles after the start cycle for n>=2, and 1 cycle after for n<=1.
REQ-022 STREAM drives dout=a and dout_valid=1; dout is stable while dout_valid=1 and dout_ready=0.
REQ-023 STREAM handshake (dout_valid and dout_ready both high), by priority:
- k==n: go to DONE.
- Else if b_ovf: overflow<=1, go to DONE.
- Else: a<=b, b<=a+b, b_ovf<=carry, k<=k+1.
REQ-024 A term whose true value does not fit in WIDTH bits is never emitted.
REQ-025 DONE: done=1 for exactly that cycle; dout and overflow hold until the next accepted start.
REQ-026 Without start, DONE returns to IDLE. With start, DONE re-launches directly, allowing back-to-back jobs.
REQ-027 start in CALC or STREAM is ignored.
REQ-028 dout_ready is ignored outside STREAM.
REQ-029 Unused state encodings recover to IDLE.

Reset
REQ-030 reset=0 at a clock edge: state IDLE, and dout, dout_valid, done, busy, overflow, a, b, k, b_ovf all 0.
REQ-031 Reset mid-job aborts the job without a done pulse and takes priority over start.

Structure
REQ-032 Shared package fib_pkg holds the state enum and default WIDTH and NW constants.
REQ-033 Sub-module fib_adder, a WIDTH-bit adder with carry-out, is instantiated once and shared by CALC and STREAM.

Verification
REQ-034 Single, n=10, WIDTH=16 -> done 11 cycles after start, dout=55, overflow=0.
REQ-035 Single, n=0 then n=1 back-to-back (start during DONE) -> dout=0 then 1, each done 1 cycle after its start.
REQ-036 Single, WIDTH=16: n=24 -> dout=46368, overflow=0; n=25 -> dout=0xFFFF, overflow=1.
REQ-037 Stream, n=5, dout_ready random -> accepted terms 0,1,1,2,3,5, dout stable while stalled, one done pulse after the last accept.
REQ-038 Stream, n=30, WIDTH=16 -> terms F(0)..F(24) accepted, then done with overflow=1; 75025 never presented.
REQ-039 Reset low in CALC cycle 3 of n=10 -> all outputs 0 next cycle, no done; start pulses in CALC are ignored.
